// File: rtl/clk_en_pkg.sv
// clk_en_pkg: shared defaults and helpers for the fractional clock-enable generator
//   ACC_W_DEF       default phase-accumulator width
//   LOCK_CYCLES_DEF default settle time before locked asserts
//   CH_W            width of the configuration channel index
//   lock_cnt_w()    counter width able to hold 0..cycles
package clk_en_pkg;

    localparam int ACC_W_DEF       = 32;
    localparam int LOCK_CYCLES_DEF = 1024;
    localparam int CH_W            = 5;

    function automatic int lock_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/clk_en_ch.sv
// clk_en_ch: one phase-accumulator channel with glitch-free increment update
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_load       accepted update for this channel (only asserted while not pending)
//   i_load_inc   increment carried by the update
//   i_sync       realign: clear accumulator, suppress pulse, commit pending update
//   o_clken      registered carry-out of the accumulator add
//   o_pending    an update is waiting for its commit point
module clk_en_ch
    import clk_en_pkg::*;
#(
    parameter int               ACC_W    = ACC_W_DEF,
    parameter logic [ACC_W-1:0] INIT_INC = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [ACC_W-1:0] i_load_inc,
    input  logic             i_sync,
    output logic             o_clken,
    output logic             o_pending
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_pend_inc;
    logic             r_pending;
    logic             r_clken;
    logic [ACC_W:0]   w_sum;
    logic             w_commit;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

    // Swapping the increment on a wrapping add keeps the current period intact;
    // a stopped channel has no period to protect, so it swaps right away.
    assign w_commit = r_pending & (i_sync | w_sum[ACC_W] | (r_inc == '0));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc      <= '0;
            r_inc      <= INIT_INC;
            r_pend_inc <= '0;
            r_pending  <= 1'b0;
            r_clken    <= 1'b0;
        end else begin
            r_acc      <= i_sync ? '0 : w_sum[ACC_W-1:0];
            r_clken    <= !i_sync & w_sum[ACC_W];
            r_inc      <= w_commit ? r_pend_inc : r_inc;
            r_pend_inc <= i_load ? i_load_inc : r_pend_inc;
            r_pending  <= i_load | (r_pending & !w_commit);
        end
    end

    assign o_clken   = r_clken;
    assign o_pending = r_pending;

endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel fractional clock-enable generator with lock indication
//   i_refclk     sole clock
//   i_rst_n      asynchronous active-low reset
//   i_cfg_valid  increment update request
//   o_cfg_ready  update can be accepted this cycle (combinational on i_cfg_ch)
//   i_cfg_ch     target channel index
//   i_cfg_inc    new increment
//   i_sync       single-cycle phase-realign request for all channels
//   o_clken      per-channel single-cycle enable pulses
//   o_cfg_err    one-cycle pulse after a request to a nonexistent channel
//   o_locked     all channels settled at their committed rates
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int                      NUM_CH      = 3,
    parameter int                      ACC_W       = ACC_W_DEF,
    parameter int                      LOCK_CYCLES = LOCK_CYCLES_DEF,
    parameter logic [NUM_CH*ACC_W-1:0] INIT_INC    = '0
) (
    input  logic              i_refclk,
    input  logic              i_rst_n,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [ACC_W-1:0]  i_cfg_inc,
    input  logic              i_sync,
    output logic [NUM_CH-1:0] o_clken,
    output logic              o_cfg_err,
    output logic              o_locked
);

    localparam int               CNT_W   = lock_cnt_w(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CYCLES);

    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_load;
    logic [31:0]       w_pend_ext;
    logic              w_ch_ok;
    logic              w_accept;
    logic              w_clear;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic              r_locked;

    // Zero-extended so indices past NUM_CH read as "not pending" and are
    // always ready; they are then swallowed and flagged as errors.
    assign w_pend_ext  = 32'(w_pending);
    assign w_ch_ok     = 32'(i_cfg_ch) < NUM_CH;
    assign o_cfg_ready = !w_pend_ext[i_cfg_ch];
    assign w_accept    = i_cfg_valid & o_cfg_ready & w_ch_ok;
    assign w_clear     = w_accept | i_sync;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_load[c] = w_accept && (i_cfg_ch == CH_W'(c));
        clk_en_ch #(
            .ACC_W    (ACC_W),
            .INIT_INC (INIT_INC[c*ACC_W +: ACC_W])
        ) u_ch (
            .i_clk      (i_refclk),
            .i_rst_n    (i_rst_n),
            .i_load     (w_load[c]),
            .i_load_inc (i_cfg_inc),
            .i_sync     (i_sync),
            .o_clken    (o_clken[c]),
            .o_pending  (w_pending[c])
        );
    end

    always_ff @(posedge i_refclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_cnt    <= w_clear ? '0 : ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1);
            r_err    <= i_cfg_valid & !w_ch_ok;
            r_locked <= (r_cnt == CNT_MAX) && !(|w_pending) && !w_clear;
        end
    end

    assign o_cfg_err = r_err;
    assign o_locked  = r_locked;

endmodule
